mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch port (IM, read-only) and the data-memory port (DM, read/write, byte mask).
- Sits between the core's fetch unit / dm_interface bus outputs and the unified memory.
- Fixed DM priority with an IM anti-starvation override.
- One outstanding read at a time; variable-latency read responses are routed back to their owner.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- STARVE_LIMIT, 4, consecutive denied IM-request cycles before IM is forced to win; legal range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imReq  in  1  IM read request; held with imAddr until imGnt
- imAddr  in  ADDR_W  IM read address
- imGnt  out  1  IM request accepted this cycle
- imRValid  out  1  IM read data valid
- imRData  out  DATA_W  IM read data
- dmReq  in  1  DM request; held with all DM fields until dmGnt
- dmWe  in  1  1=store, 0=load
- dmAddr  in  ADDR_W  DM address
- dmWData  in  DATA_W  store data, already lane-aligned
- dmMask  in  DATA_W/8  store byte mask
- dmGnt  out  1  DM request accepted this cycle
- dmRValid  out  1  DM load data valid
- dmRData  out  DATA_W  DM load data, raw word
- memAddr  out  ADDR_W  shared bus address
- memWData  out  DATA_W  shared bus write data
- memMask  out  DATA_W/8  shared bus byte mask
- memWe  out  1  write strobe
- memRe  out  1  read strobe
- memReady  in  1  memory accepts a command this cycle
- memRValid  in  1  read response valid
- memRData  in  DATA_W  read response data

Behaviour:
- State: FSM {IDLE, WAIT_RESP}, owner register {OWN_IM, OWN_DM}, starveCnt (4 bit).
- Reset values: IDLE, OWN_DM, starveCnt=0. While rst_n is low, all gnt, rvalid, memWe and memRe are 0.
- Issue window: open when state==IDLE, or when state==WAIT_RESP and memRValid=1 (back-to-back reads allowed).
- Arbitration, combinational, evaluated only inside an open issue window with memReady=1:
  - IM wins if imReq and (!dmReq or starveCnt>=STARVE_LIMIT).
  - Otherwise DM wins if dmReq.
- Grant cycle:
  - The winner's gnt=1 and the mem bus carries its fields in that same cycle.
  - memRe = winner is IM, or winner is DM with dmWe=0.
  - memWe = winner is DM with dmWe=1.
  - For IM grants, memMask=all ones and memWData=0.
- When not granting: memWe=memRe=0, memAddr/memWData/memMask = DM fields (don't-care).
- Read grant: the next state is WAIT_RESP and owner takes the winner.
- Write grant: completes in the grant cycle; the next state is IDLE unless a read was issued.
- memRValid in WAIT_RESP:
  - Pulse rvalid of the owner only, for one cycle.
  - imRData and dmRData both equal memRData at all times.
  - Next state follows the issue-window rule: WAIT_RESP if a new read was granted, else IDLE.
- memRValid in IDLE: ignored, no rvalid pulse; covered by a simulation assertion.
- Requests in WAIT_RESP without memRValid are held; no gnt is issued.
- starveCnt:
  - Increments, saturating at 15, each cycle imReq=1 and imGnt=0 inside an open issue window with memReady=1.
  - Clears on imGnt.
  - Holds otherwise.
- memReady=0: no grants, and starveCnt holds.
- Reset asserted mid-read: the outstanding response is abandoned; a late memRValid lands in IDLE and is dropped.
- Latency: grant is 0 cycles after req when the bus is free. Response latency equals memory latency, with no added cycles.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum arb_state_e {IDLE, WAIT_RESP}
  - typedef enum arb_owner_e {OWN_IM, OWN_DM}
  - localparam STARVE_CNT_W = 4
- One sub-module mem_arb_starve_ctr: saturating counter with inc/clr/hold inputs and a limit-compare output.

Test Plan:
- Reset with both reqs high and rst_n=0 → all gnt/rvalid/memWe/memRe are 0; after release with memReady=1, dmGnt=1 first cycle, memAddr=dmAddr.
- DM store dmAddr=0x100, dmWData=0x0000AB00, dmMask=0010 → same-cycle dmGnt, memWe=1, mask 0010, state stays IDLE; a following IM read is granted next cycle.
- IM read 0x40, memRValid 3 cycles later with 0xDEADBEEF → imRValid=1 for exactly 1 cycle, imRData=0xDEADBEEF, dmRValid=0; DM req during the wait gets no gnt until the memRValid cycle (back-to-back).
- Both reqs asserted continuously, DM loads completing in 1 cycle, STARVE_LIMIT=4 → DM granted 4 times, 5th grant goes to IM, starveCnt returns to 0.
- memReady=0 for 6 cycles with imReq and dmReq high → no gnt, starveCnt unchanged; memReady=1 → DM granted.
- Reset pulse while WAIT_RESP (owner IM), then memRValid arrives → no imRValid or dmRValid; state IDLE; assertion fires.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IM/DM memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM: either free to issue, or waiting on one outstanding read.
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } arb_state_e;

  // Which port the outstanding read response belongs to.
  typedef enum logic {
    OWN_IM = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Width of the IM starvation counter; it saturates at all ones.
  localparam int STARVE_CNT_W = 4;
  localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating counter of consecutive IM denials, with a limit compare that
// lets the arbiter override DM priority once IM has waited long enough.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    hold,
  output logic [STARVE_CNT_W-1:0] cnt,
  output logic                    atLimit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_VAL = STARVE_CNT_W'(LIMIT);

  // Clear wins over everything; hold freezes; inc stops at the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (inc && (cnt != STARVE_CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign atLimit = (cnt >= LIMIT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the instruction-fetch port
// (read only) and the data-memory port (read/write with byte mask).
// DM has fixed priority; IM is forced through after STARVE_LIMIT consecutive
// denied cycles. One read may be outstanding; a new read can be issued in the
// same cycle the previous response returns.
//
// Handshake: a requester holds req and all of its fields stable until it sees
// gnt high in a cycle; that cycle the command is on the memory bus and memory
// accepts it (memReady=1). Read responses are single-cycle rvalid pulses
// routed to the port that issued the read; there is no back-pressure on them.
//
// STARVE_LIMIT must lie in 1..15 so that the saturating counter can reach it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction-fetch port
  input  logic                    imReq,
  input  logic [ADDR_W-1:0]       imAddr,
  output logic                    imGnt,
  output logic                    imRValid,
  output logic [DATA_W-1:0]       imRData,
  // data-memory port
  input  logic                    dmReq,
  input  logic                    dmWe,
  input  logic [ADDR_W-1:0]       dmAddr,
  input  logic [DATA_W-1:0]       dmWData,
  input  logic [DATA_W/8-1:0]     dmMask,
  output logic                    dmGnt,
  output logic                    dmRValid,
  output logic [DATA_W-1:0]       dmRData,
  // shared memory bus
  output logic [ADDR_W-1:0]       memAddr,
  output logic [DATA_W-1:0]       memWData,
  output logic [DATA_W/8-1:0]     memMask,
  output logic                    memWe,
  output logic                    memRe,
  input  logic                    memReady,
  input  logic                    memRValid,
  input  logic [DATA_W-1:0]       memRData,
  // debug visibility of internal state
  output arb_state_e              dbgState,
  output arb_owner_e              dbgOwner,
  output logic [STARVE_CNT_W-1:0] dbgStarveCnt
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e              state;
  arb_owner_e              owner;
  logic [STARVE_CNT_W-1:0] starveCnt;
  logic                    starveHit;

  logic issueWin;
  logic arbEn;
  logic imWin;
  logic dmWin;
  logic readIssue;
  logic respHit;

  // Arbitration: only inside an open issue window with memory ready.
  always_comb begin
    issueWin  = (state == IDLE) || ((state == WAIT_RESP) && memRValid);
    arbEn     = rst_n && issueWin && memReady;
    imWin     = arbEn && imReq && (!dmReq || starveHit);
    dmWin     = arbEn && dmReq && !imWin;
    readIssue = imWin || (dmWin && !dmWe);
    respHit   = rst_n && (state == WAIT_RESP) && memRValid;
  end

  // Bus mux: winner's fields during a grant, DM fields (don't-care) otherwise.
  always_comb begin
    imGnt    = imWin;
    dmGnt    = dmWin;
    memRe    = readIssue;
    memWe    = dmWin && dmWe;
    memAddr  = imWin ? imAddr : dmAddr;
    memWData = imWin ? '0 : dmWData;
    memMask  = imWin ? {MASK_W{1'b1}} : dmMask;
    imRValid = respHit && (owner == OWN_IM);
    dmRValid = respHit && (owner == OWN_DM);
    imRData  = memRData;
    dmRData  = memRData;
  end

  // FSM and owner: a read grant opens a wait, a response without a new read closes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_DM;
    end else if (readIssue) begin
      state <= WAIT_RESP;
      owner <= imWin ? OWN_IM : OWN_DM;
    end else if ((state == WAIT_RESP) && memRValid) begin
      state <= IDLE;
    end
  end

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (arbEn && imReq && !imWin),
    .clr     (imWin),
    .hold    (!memReady),
    .cnt     (starveCnt),
    .atLimit (starveHit)
  );

  assign dbgState     = state;
  assign dbgOwner     = owner;
  assign dbgStarveCnt = starveCnt;

  // A response with no read outstanding is dropped; flag it in simulation.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((state == IDLE) && memRValid))
        else $warning("mem_port_arbiter: memRValid with no read outstanding, response dropped");
    end
  end

endmodule
